// File: rtl/mips_pkg.sv
// Shared types and constants for the iterative divider.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        CALC,
        DONE
    } div_state_t;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder/quotient pair left,
// trial-subtract the divisor and shift in the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] work_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    always_comb begin
        partial = work_i[2*WIDTH-1:WIDTH-1];
        diff    = partial - {1'b0, divisor_i};
        // Borrow out of the 33-bit difference means partial < divisor.
        if (!diff[WIDTH]) begin
            work_o = {diff[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
        end else begin
            work_o = {partial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle div/divu unit for the Execute stage: 32-cycle restoring divide,
// fast divide-by-zero path, pipeline stall request and annul support.
//   state   | meaning
//   IDLE    | waiting for start; operands latched on acceptance
//   DIVZERO | divisor was zero; result fixed on the next edge
//   CALC    | 32 restoring iterations, one quotient bit per cycle
//   DONE    | result valid, done pulse, pipeline released
module div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic [2*WIDTH-1:0] step_work;
    logic               a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    assign a_neg = signed_div & opa[WIDTH-1];
    assign b_neg = signed_div & opb[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        divisor_d   = divisor_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    if (opb == '0) begin
                        state_d = DIVZERO;
                        work_d  = {{WIDTH{1'b0}}, opa};
                    end else begin
                        state_d   = CALC;
                        cnt_d     = 6'(DIV_ITERS - 1);
                        work_d    = {{WIDTH{1'b0}}, neg_if(a_neg, opa)};
                        divisor_d = neg_if(b_neg, opb);
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                    end
                end
            end
            CALC: begin
                work_d = step_work;
                cnt_d  = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d     = DONE;
                    quotient_d  = neg_if(q_neg_q, step_work[WIDTH-1:0]);
                    remainder_d = neg_if(r_neg_q, step_work[2*WIDTH-1:WIDTH]);
                end
            end
            DIVZERO: begin
                state_d     = DONE;
                quotient_d  = DIV_ZERO_QUOT;
                remainder_d = work_q[WIDTH-1:0];
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flushed operation must leave the previous result visible.
        if (annul) begin
            state_d     = IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign done      = (state_q == DONE);
    assign stall_req = resetn & (((state_q == IDLE) & start & !annul) |
                                 (state_q == CALC) | (state_q == DIVZERO));
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, ignored inputs during CALC, back-to-back issue and reset.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp = 0;
    int n_err = 0;

    // signed, dividend, divisor, expected quotient, expected remainder
    logic        sv_s[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] sv_a[6] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9,
                             32'h80000000, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] sv_b[6] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE,
                             32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    logic [31:0] sv_q[6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000003,
                             32'h80000000, 32'h7FFFFFFC, 32'h00000000};
    logic [31:0] sv_r[6] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                             32'h00000000, 32'h00000001, 32'h80000000};

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall_req  (stall_req),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        start      = 1'b1;
        signed_div = s;
        opa        = a;
        opb        = b;
    endtask

    // Returns the number of negedges until done is seen, or -1 on timeout.
    task automatic wait_done(input bit hold, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        launch(1'b0, 32'd1, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_req); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_q got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_r got %h want 0", remainder); end
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL post_reset got %b want 00", {stall_req, done}); end
    endtask

    task automatic test_divu_basic();
        launch(1'b0, 32'd7, 32'd2);
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL basic_stall_T got %b want 1", stall_req); end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if ({stall_req, done} !== 2'b10) begin n_err++; $display("FAIL basic_calc_%0d stall/done got %b want 10", k, {stall_req, done}); end
        end
        @(negedge clk);
        n_cmp++; if ({stall_req, done} !== 2'b01) begin n_err++; $display("FAIL basic_T33 stall/done got %b want 01", {stall_req, done}); end
        n_cmp++; if (quotient !== 32'd3) begin n_err++; $display("FAIL basic_q got %h want 3", quotient); end
        n_cmp++; if (remainder !== 32'd1) begin n_err++; $display("FAIL basic_r got %h want 1", remainder); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_signed();
        int c;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            launch(sv_s[v], sv_a[v], sv_b[v]);
            wait_done(1'b0, c);
            n_cmp++; if (c !== 33) begin n_err++; $display("FAIL vec%0d_latency got %0d want 33", v, c); end
            n_cmp++; if (quotient !== sv_q[v]) begin n_err++; $display("FAIL vec%0d_q got %h want %h", v, quotient, sv_q[v]); end
            n_cmp++; if (remainder !== sv_r[v]) begin n_err++; $display("FAIL vec%0d_r got %h want %h", v, remainder, sv_r[v]); end
        end
    endtask

    task automatic test_divzero();
        int c;
        @(negedge clk);
        launch(1'b0, 32'd5, 32'd0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({stall_req, done} !== 2'b10) begin n_err++; $display("FAIL dz_T1 stall/done got %b want 10", {stall_req, done}); end
        @(negedge clk);
        n_cmp++; if ({stall_req, done} !== 2'b01) begin n_err++; $display("FAIL dz_T2 stall/done got %b want 01", {stall_req, done}); end
        n_cmp++; if (quotient !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_q got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'd5) begin n_err++; $display("FAIL dz_r got %h want 5", remainder); end
        @(negedge clk);
        launch(1'b1, 32'hFFFFFFF9, 32'd0);
        wait_done(1'b0, c);
        n_cmp++; if (c !== 2) begin n_err++; $display("FAIL dz_signed_latency got %0d want 2", c); end
        n_cmp++; if (quotient !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_signed_q got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'hFFFFFFF9) begin n_err++; $display("FAIL dz_signed_r got %h want fffffff9", remainder); end
    endtask

    task automatic test_annul();
        int c;
        @(negedge clk);
        launch(1'b0, 32'd9, 32'd3);
        annul = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL annul_prio_stall got %b want 0", stall_req); end
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        #1;
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL annul_prio_idle got %b want 00", {stall_req, done}); end
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL annul_T11 stall/done got %b want 00", {stall_req, done}); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL annul_no_done cycle %0d got %b want 0", k, done); end
        end
        n_cmp++; if (quotient !== 32'hFFFFFFFF) begin n_err++; $display("FAIL annul_q_kept got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'hFFFFFFF9) begin n_err++; $display("FAIL annul_r_kept got %h want fffffff9", remainder); end
        launch(1'b0, 32'd9, 32'd3);
        wait_done(1'b0, c);
        n_cmp++; if (c !== 33) begin n_err++; $display("FAIL annul_next_latency got %0d want 33", c); end
        n_cmp++; if (quotient !== 32'd3) begin n_err++; $display("FAIL annul_next_q got %h want 3", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL annul_next_r got %h want 0", remainder); end
    endtask

    task automatic test_ignore_inputs();
        int c;
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        repeat (2) begin
            @(negedge clk);
            start = 1'b0;
        end
        launch(1'b1, 32'hFFFFFFFF, 32'd0);
        repeat (5) @(negedge clk);
        start = 1'b0;
        opa   = 32'd0;
        opb   = 32'd0;
        wait_done(1'b0, c);
        n_cmp++; if (c !== 26) begin n_err++; $display("FAIL ignore_latency got %0d want 26", c); end
        n_cmp++; if (quotient !== 32'd14) begin n_err++; $display("FAIL ignore_q got %h want e", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_err++; $display("FAIL ignore_r got %h want 2", remainder); end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        launch(1'b0, 32'd10, 32'd3);
        wait_done(1'b1, c);
        n_cmp++; if (c !== 33) begin n_err++; $display("FAIL b2b_first_latency got %0d want 33", c); end
        n_cmp++; if (quotient !== 32'd3) begin n_err++; $display("FAIL b2b_first_q got %h want 3", quotient); end
        n_cmp++; if (remainder !== 32'd1) begin n_err++; $display("FAIL b2b_first_r got %h want 1", remainder); end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL b2b_no_relaunch got %b want 00", {stall_req, done}); end
        @(negedge clk);
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL b2b_single_done got %b want 00", {stall_req, done}); end
        launch(1'b0, 32'd20, 32'd6);
        wait_done(1'b0, c);
        n_cmp++; if (c !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d want 33", c); end
        n_cmp++; if (quotient !== 32'd3) begin n_err++; $display("FAIL b2b_second_q got %h want 3", quotient); end
        n_cmp++; if (remainder !== 32'd2) begin n_err++; $display("FAIL b2b_second_r got %h want 2", remainder); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL midrst_ctrl got %b want 00", {stall_req, done}); end
        n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL midrst_q got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL midrst_r got %h want 0", remainder); end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++; if ({stall_req, done} !== 2'b00) begin n_err++; $display("FAIL midrst_quiet cycle %0d got %b want 00", k, {stall_req, done}); end
        end
        n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL midrst_q_after got %h want 0", quotient); end
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        annul      = 1'b0;
        @(negedge clk);
        test_reset();
        test_divu_basic();
        test_signed();
        test_divzero();
        test_annul();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
